// File: rtl/lift_door_ctrl.sv
// Lift car door-drive controller: sequences the door motor between limit switches, holds open for a dwell,
// reopens on obstruction, interlocks against car motion and latches faults until reset. Moore outputs, 1-cycle latency.
module lift_door_ctrl #(
  parameter int DWELL_CYCLES   = 100,
  parameter int TRAVEL_TIMEOUT = 500,
  parameter int TIMER_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       open_req,
  input  logic       close_req,
  input  logic       obstruction,
  input  logic       door_open_limit,
  input  logic       door_closed_limit,
  input  logic       motor_on,
  input  logic       emergency,
  output logic       door_motor_open,
  output logic       door_motor_close,
  output logic       doors_closed,
  output logic [2:0] door_state,
  output logic       fault
);

  typedef enum logic [2:0] {
    ST_CLOSED    = 3'd0,
    ST_OPENING   = 3'd1,
    ST_OPEN_HOLD = 3'd2,
    ST_CLOSING   = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam logic [TIMER_W-1:0] DWELL_LD    = TIMER_W'(DWELL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

  state_t              r_state;
  state_t              w_next;
  logic [TIMER_W-1:0]  r_timer;
  logic [TIMER_W-1:0]  w_timer_next;
  logic [TIMER_W-1:0]  w_timer_inc;
  logic [TIMER_W-1:0]  w_timer_dec;
  logic                w_hold;
  logic                w_safety_trip;
  logic                r_motor_open;
  logic                r_motor_close;
  logic                r_doors_closed;
  logic                r_fault;

  always_comb begin
    w_next       = r_state;
    w_timer_next = '0;
    // Saturating steps so a misconfigured timeout can never wrap the timer.
    w_timer_inc  = (r_timer == TIMER_MAX) ? r_timer : r_timer + TIMER_ONE;
    w_timer_dec  = (r_timer == '0) ? r_timer : r_timer - TIMER_ONE;
    w_hold       = open_req | obstruction | emergency;
    w_safety_trip = (door_open_limit & door_closed_limit) |
                    (motor_on & (r_state != ST_CLOSED));

    case (r_state)
      ST_CLOSED: begin
        if (!motor_on) begin
          if (open_req || emergency) begin
            w_next = ST_OPENING;
          end else if (!door_closed_limit) begin
            w_next = ST_CLOSING;
          end
        end
      end
      ST_OPENING: begin
        if (door_open_limit) begin
          w_next       = ST_OPEN_HOLD;
          w_timer_next = DWELL_LD;
        end else if (r_timer == TRAVEL_LAST) begin
          w_next = ST_FAULT;
        end else begin
          w_timer_next = w_timer_inc;
        end
      end
      ST_OPEN_HOLD: begin
        if (w_hold) begin
          w_timer_next = DWELL_LD;
        end else if (close_req || r_timer == '0) begin
          w_next = ST_CLOSING;
        end else begin
          w_timer_next = w_timer_dec;
        end
      end
      ST_CLOSING: begin
        if (obstruction || open_req) begin
          w_next = ST_OPENING;
        end else if (door_closed_limit) begin
          w_next = ST_CLOSED;
        end else if (r_timer == TRAVEL_LAST) begin
          w_next = ST_FAULT;
        end else begin
          w_timer_next = w_timer_inc;
        end
      end
      ST_FAULT: w_next = ST_FAULT;
      default:  w_next = ST_FAULT;
    endcase

    // Limit-switch contradiction and car-motion interlock override any per-state decision.
    if (r_state != ST_FAULT && w_safety_trip) begin
      w_next       = ST_FAULT;
      w_timer_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= ST_CLOSED;
      r_timer        <= '0;
      r_motor_open   <= 1'b0;
      r_motor_close  <= 1'b0;
      r_doors_closed <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_timer        <= w_timer_next;
      r_motor_open   <= (w_next == ST_OPENING);
      r_motor_close  <= (w_next == ST_CLOSING);
      r_fault        <= (w_next == ST_FAULT);
      r_doors_closed <= (r_state == ST_CLOSED) && door_closed_limit;
    end
  end

  assign door_motor_open  = r_motor_open;
  assign door_motor_close = r_motor_close;
  assign doors_closed     = r_doors_closed;
  assign fault            = r_fault;
  assign door_state       = r_state;

endmodule

// File: doc/lift_door_ctrl.md
Name: lift_door_ctrl

Overview:
Door-drive controller for the lift car, directly upstream of the lift FSM (lift_con). It generates the doors_closed signal that lift_con consumes. It also takes lift_con's motor_on back as an interlock so the doors never open while the car moves. Internally it sequences the door motor between limit switches, holds the door open for a dwell time, reopens on obstruction, and latches a fault on travel timeout or interlock violation.

Parameters:
DWELL_CYCLES, 100, cycles the door stays fully open before auto-close (>=1)
TRAVEL_TIMEOUT, 500, max cycles allowed in OPENING or CLOSING before fault (>=2)
TIMER_W, 16, timer width; must hold max(DWELL_CYCLES, TRAVEL_TIMEOUT)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
open_req  input  1  open/hold request (car call at floor, door-open button)
close_req  input  1  door-close button
obstruction  input  1  light-curtain/edge sensor, 1 = blocked
door_open_limit  input  1  1 = door fully open
door_closed_limit  input  1  1 = door fully closed
motor_on  input  1  car motor running (from lift_con)
emergency  input  1  emergency mode
door_motor_open  output  1  drive door motor in open direction
door_motor_close  output  1  drive door motor in close direction
doors_closed  output  1  door confirmed closed and locked (to lift_con)
door_state  output  3  current state encoding
fault  output  1  latched door fault

Behaviour:
- States and encodings: CLOSED=0, OPENING=1, OPEN_HOLD=2, CLOSING=3, FAULT=4. Codes 5-7 are illegal and go to FAULT on the next edge.
- Moore machine. All outputs are registered and decoded from state. Any input affects outputs exactly 1 cycle after the sampling edge.
- Reset (reset==0 at posedge):
  - state=CLOSED, timer=0.
  - door_motor_open=0, door_motor_close=0, doors_closed=0, fault=0, door_state=0.
  - Reset takes priority mid-operation, including exit from FAULT; no other exit from FAULT exists.
- Outputs per state:
  - door_motor_open=1 only in OPENING.
  - door_motor_close=1 only in CLOSING.
  - fault=1 only in FAULT.
  - doors_closed is registered: it is 1 on a cycle only if the previous edge saw state CLOSED with door_closed_limit=1; otherwise 0.
- Priority in every non-FAULT state, highest first:
  1. Both limit inputs = 1, or motor_on=1 while state != CLOSED -> FAULT.
  2. The per-state rules below.
- CLOSED:
  - motor_on=1: stay; open_req and emergency are ignored.
  - else open_req=1 or emergency=1 -> OPENING.
  - else door_closed_limit=0 (door drift) -> CLOSING.
- OPENING:
  - timer clears on entry and increments each cycle.
  - door_open_limit=1 -> OPEN_HOLD.
  - else timer==TRAVEL_TIMEOUT-1 -> FAULT.
- OPEN_HOLD:
  - timer loads DWELL_CYCLES-1 on entry and decrements each cycle.
  - open_req, obstruction or emergency reload DWELL_CYCLES-1; open_req beats a simultaneous close_req.
  - close_req=1 with no hold condition and emergency=0 -> CLOSING immediately.
  - timer==0 with no hold condition -> CLOSING.
  - With no requests, the state lasts exactly DWELL_CYCLES cycles.
- CLOSING:
  - timer clears on entry and increments each cycle.
  - obstruction=1 or open_req=1 -> OPENING (reopen); timer clears.
  - else door_closed_limit=1 -> CLOSED.
  - else timer==TRAVEL_TIMEOUT-1 -> FAULT.
- FAULT: motors off, doors_closed=0 (holds lift_con at rest), stays until reset.
- Timer:
  - TIMER_W-bit unsigned.
  - Never wraps; it saturates at all-ones if parameters are misconfigured.
  - Cleared or reloaded on every state entry.
- obstruction is ignored in CLOSED and OPENING.

Test Plan (DWELL_CYCLES=8, TRAVEL_TIMEOUT=20):
- Normal cycle: from CLOSED with closed_limit=1, pulse open_req.
  - door_motor_open=1 next cycle; assert open_limit after 5 cycles -> OPEN_HOLD.
  - door_motor_close rises exactly 8 cycles later; assert closed_limit -> CLOSED.
  - doors_closed=1 one cycle after that.
- Obstruction reopen: during CLOSING, obstruction=1 -> door_state=1, door_motor_close=0, door_motor_open=1 next cycle.
- Dwell extend and close button:
  - In OPEN_HOLD, pulse open_req at dwell cycle 6 -> a full 8 further cycles of hold.
  - close_req alone at cycle 2 -> CLOSING next edge.
  - open_req and close_req together -> remains OPEN_HOLD.
- Interlock:
  - motor_on=1 in CLOSED plus open_req -> stays CLOSED, motors off.
  - motor_on=1 during OPEN_HOLD -> fault=1, doors_closed=0.
- Timeout: OPENING with open_limit never asserted -> FAULT after exactly 20 cycles. Holds through further requests; reset=0 for one edge -> all outputs 0, state CLOSED.
- Emergency: emergency=1 in CLOSED with motor_on=0 -> OPENING. In OPEN_HOLD with emergency held, close_req is ignored and the door never closes.
